fm_port_arb: RTL and testbench

- Arbiter and sequencer for the EDP fast-memory (FM) AC block array, 128 x 36, with two 18-bit halfword write enables.
- Shares the single FM port between two requesters:
  - the EBOX microcode path (normal priority winner);
  - the diagnostic/console EBUS path (DIAG).
- Prevents DIAG starvation with a bounded-wait counter.
- Supports an exclusive diagnostic lock.
- Sits between the EBOX control logic, the console diagnostic interface, and the FM RAM in the EDP.

---
 rtl/fm_port_arb.sv | 164 ++++++++++++++++
 tb/tb_fm_port_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_port_arb.sv
// fm_port_arb
//   Arbiter/sequencer for the single port of the EDP fast-memory (FM) AC
//   block array (128 x 36, two 18-bit halfword write enables).  Two
//   requesters share the port:
//     EBOX  - microcode path, normal priority winner
//     DIAG  - console/EBUS diagnostic path, with a bounded wait so that a
//             busy EBOX cannot starve it, plus an exclusive lock (diag_lock)
//             that keeps EBOX off the port entirely.
//
// Ports
//   clk, crobar_n              clock, synchronous active-low reset
//   ebox_req/we/addr/wdata     EBOX request (we: [0]=bits 0:17, [1]=bits 18:35,
//                              2'b00 = read); held stable until ebox_gnt
//   ebox_gnt                   EBOX accepted this cycle (combinational)
//   ebox_rvalid/rdata          EBOX read return, one cycle after the grant
//   diag_*                     DIAG equivalents of the above
//   diag_lock                  1 = EBOX is never granted
//   rparity                    XOR of the rdata currently valid, 0 if none
//   fm_addr/wdata/we           FM RAM port, driven in the grant cycle
//   fm_rdata                   FM RAM synchronous read data (1-cycle latency)
//   starve_cnt                 consecutive contended EBOX grants seen by DIAG
module fm_port_arb #(
  parameter int AW            = 7,
  parameter int DW            = 36,
  parameter int DIAG_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          crobar_n,

  input  logic          ebox_req,
  input  logic [1:0]    ebox_we,
  input  logic [AW-1:0] ebox_addr,
  input  logic [DW-1:0] ebox_wdata,
  output logic          ebox_gnt,
  output logic          ebox_rvalid,
  output logic [DW-1:0] ebox_rdata,

  input  logic          diag_req,
  input  logic [1:0]    diag_we,
  input  logic [AW-1:0] diag_addr,
  input  logic [DW-1:0] diag_wdata,
  output logic          diag_gnt,
  output logic          diag_rvalid,
  output logic [DW-1:0] diag_rdata,

  input  logic          diag_lock,
  output logic          rparity,

  output logic [AW-1:0] fm_addr,
  output logic [DW-1:0] fm_wdata,
  output logic [1:0]    fm_we,
  input  logic [DW-1:0] fm_rdata,

  output logic [3:0]    starve_cnt
);

  localparam logic [3:0] MAX_WAIT = 4'(DIAG_MAX_WAIT);

  // Which requester the read data arriving next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_EBOX = 2'd1,
    OWN_DIAG = 2'd2
  } owner_e;

  owner_e        rd_owner_reg,   rd_owner_next;
  logic [3:0]    starve_cnt_reg, starve_cnt_next;
  logic [AW-1:0] last_addr_reg,  last_addr_next;

  logic          ebox_cand;
  logic          diag_cand;
  logic          diag_forced;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!crobar_n) begin
      rd_owner_reg   <= OWN_NONE;
      starve_cnt_reg <= '0;
      last_addr_reg  <= '0;
    end else begin
      rd_owner_reg   <= rd_owner_next;
      starve_cnt_reg <= starve_cnt_next;
      last_addr_reg  <= last_addr_next;
    end
  end

  // ------------------------------------------------------------------
  // Grant selection, port drive and next state
  // ------------------------------------------------------------------
  always_comb begin
    ebox_gnt        = 1'b0;
    diag_gnt        = 1'b0;
    fm_addr         = last_addr_reg;   // idle/reset: hold the last address
    fm_wdata        = '0;
    fm_we           = 2'b00;
    rd_owner_next   = OWN_NONE;
    last_addr_next  = last_addr_reg;
    starve_cnt_next = starve_cnt_reg;

    ebox_cand   = ebox_req & ~diag_lock;
    diag_cand   = diag_req;
    diag_forced = diag_cand && (starve_cnt_reg == MAX_WAIT);

    // Reset gates every grant so a request held across reset waits for
    // the first cycle with crobar_n high.
    if (crobar_n) begin
      if (ebox_cand && !diag_forced) begin
        ebox_gnt = 1'b1;
      end else if (diag_cand) begin
        diag_gnt = 1'b1;
      end
    end

    if (ebox_gnt) begin
      fm_addr        = ebox_addr;
      fm_wdata       = ebox_wdata;
      fm_we          = ebox_we;
      last_addr_next = ebox_addr;
      if (ebox_we == 2'b00) rd_owner_next = OWN_EBOX;
    end else if (diag_gnt) begin
      fm_addr        = diag_addr;
      fm_wdata       = diag_wdata;
      fm_we          = diag_we;
      last_addr_next = diag_addr;
      if (diag_we == 2'b00) rd_owner_next = OWN_DIAG;
    end

    // Count only EBOX grants that DIAG actually lost; any DIAG grant or a
    // withdrawn DIAG request restarts the wait.
    if (!diag_req || diag_gnt) begin
      starve_cnt_next = '0;
    end else if (ebox_gnt) begin
      if (starve_cnt_reg < MAX_WAIT) starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  // ------------------------------------------------------------------
  // Read return: index 0 = EBOX, index 1 = DIAG.  Data is gated so the
  // requester that did not issue the read never sees the word.
  // ------------------------------------------------------------------
  logic [1:0]    rvalid_vec;
  logic [DW-1:0] rdata_vec [2];

  assign rvalid_vec = {rd_owner_reg == OWN_DIAG, rd_owner_reg == OWN_EBOX};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      assign rdata_vec[gi] = rvalid_vec[gi] ? fm_rdata : '0;
    end
  endgenerate

  assign ebox_rvalid = rvalid_vec[0];
  assign diag_rvalid = rvalid_vec[1];
  assign ebox_rdata  = rdata_vec[0];
  assign diag_rdata  = rdata_vec[1];

  // At most one rvalid is set, so OR-ing the gated words selects it.
  assign rparity     = ^(rdata_vec[0] | rdata_vec[1]);

  assign starve_cnt  = starve_cnt_reg;

endmodule

// File: tb/tb_fm_port_arb.sv
// Directed bench for fm_port_arb with a behavioural FM RAM (128 x 36,
// we[0] writes bits 0:17 = [35:18], we[1] writes bits 18:35 = [17:0],
// one-cycle registered read).
module tb_fm_port_arb;

  localparam int AW = 7;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          crobar_n;
  logic          ebox_req;
  logic [1:0]    ebox_we;
  logic [AW-1:0] ebox_addr;
  logic [DW-1:0] ebox_wdata;
  logic          ebox_gnt;
  logic          ebox_rvalid;
  logic [DW-1:0] ebox_rdata;
  logic          diag_req;
  logic [1:0]    diag_we;
  logic [AW-1:0] diag_addr;
  logic [DW-1:0] diag_wdata;
  logic          diag_gnt;
  logic          diag_rvalid;
  logic [DW-1:0] diag_rdata;
  logic          diag_lock;
  logic          rparity;
  logic [AW-1:0] fm_addr;
  logic [DW-1:0] fm_wdata;
  logic [1:0]    fm_we;
  logic [DW-1:0] fm_rdata;
  logic [3:0]    starve_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fm_port_arb #(.AW(AW), .DW(DW), .DIAG_MAX_WAIT(4)) dut (
    .clk         (clk),
    .crobar_n    (crobar_n),
    .ebox_req    (ebox_req),
    .ebox_we     (ebox_we),
    .ebox_addr   (ebox_addr),
    .ebox_wdata  (ebox_wdata),
    .ebox_gnt    (ebox_gnt),
    .ebox_rvalid (ebox_rvalid),
    .ebox_rdata  (ebox_rdata),
    .diag_req    (diag_req),
    .diag_we     (diag_we),
    .diag_addr   (diag_addr),
    .diag_wdata  (diag_wdata),
    .diag_gnt    (diag_gnt),
    .diag_rvalid (diag_rvalid),
    .diag_rdata  (diag_rdata),
    .diag_lock   (diag_lock),
    .rparity     (rparity),
    .fm_addr     (fm_addr),
    .fm_wdata    (fm_wdata),
    .fm_we       (fm_we),
    .fm_rdata    (fm_rdata),
    .starve_cnt  (starve_cnt)
  );

  // FM RAM model
  logic [DW-1:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (fm_we[0]) mem[fm_addr][35:18] <= fm_wdata[35:18];
    if (fm_we[1]) mem[fm_addr][17:0]  <= fm_wdata[17:0];
    fm_rdata <= mem[fm_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Starvation table: grant to DIAG and starve_cnt seen in each cycle.
  logic exp_dg  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int   exp_cnt [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

  initial begin
    crobar_n   = 1'b0;
    diag_lock  = 1'b0;
    ebox_req   = 1'b1; ebox_we = 2'b00; ebox_addr = 7'o03; ebox_wdata = '0;
    diag_req   = 1'b1; diag_we = 2'b00; diag_addr = 7'o05; diag_wdata = '0;

    // ---------------- reset with both requests pending
    for (int c = 0; c < 2; c++) begin
      tick();
      mid();
      $display("txn reset cycle %0d", c);
      chk("rst_ebox_gnt", ebox_gnt, 1'b0);
      chk("rst_diag_gnt", diag_gnt, 1'b0);
      chk("rst_fm_we", fm_we, 2'b00);
      chk("rst_starve", starve_cnt, 4'd0);
      chk("rst_fm_addr", fm_addr, 7'o00);
      chk("rst_rvalid", {ebox_rvalid, diag_rvalid}, 2'b00);
    end
    tick();
    crobar_n = 1'b1;
    mid();
    $display("txn release reset: EBOX read 03 vs DIAG");
    chk("rel_ebox_gnt", ebox_gnt, 1'b1);
    chk("rel_diag_gnt", diag_gnt, 1'b0);
    chk("rel_fm_addr", fm_addr, 7'o03);
    tick();
    ebox_req = 1'b0; diag_req = 1'b0;
    mid();
    chk("rel_starve1", starve_cnt, 4'd1);
    chk("rel_ebox_rvalid", ebox_rvalid, 1'b1);
    chk("rel_ebox_rdata", ebox_rdata, 36'o0);

    // ---------------- EBOX full write then read of 017
    tick();
    ebox_req = 1'b1; ebox_we = 2'b11; ebox_addr = 7'o17; ebox_wdata = 36'o123456701234;
    mid();
    $display("txn EBOX write 017");
    chk("ew_gnt", ebox_gnt, 1'b1);
    chk("ew_fm_we", fm_we, 2'b11);
    chk("ew_fm_addr", fm_addr, 7'o17);
    chk("ew_fm_wdata", fm_wdata, 36'o123456701234);
    chk("ew_starve_clr", starve_cnt, 4'd0);
    tick();
    ebox_we = 2'b00;
    mid();
    $display("txn EBOX read 017");
    chk("er_gnt", ebox_gnt, 1'b1);
    chk("er_fm_we", fm_we, 2'b00);
    chk("er_no_rvalid_after_write", ebox_rvalid, 1'b0);
    tick();
    ebox_req = 1'b0;
    mid();
    chk("er_rvalid", ebox_rvalid, 1'b1);
    chk("er_rdata", ebox_rdata, 36'o123456701234);
    chk("er_parity", rparity, 1'b1);
    chk("er_diag_rvalid", diag_rvalid, 1'b0);
    chk("er_diag_rdata", diag_rdata, 36'o0);
    chk("idle_fm_addr", fm_addr, 7'o17);
    chk("idle_fm_wdata", fm_wdata, 36'o0);
    tick();
    mid();
    chk("er_rvalid_one_cycle", ebox_rvalid, 1'b0);
    chk("er_rdata_gated", ebox_rdata, 36'o0);
    chk("er_parity_idle", rparity, 1'b0);

    // ---------------- DIAG halfword writes to 005
    tick();
    diag_req = 1'b1; diag_addr = 7'o05; diag_we = 2'b11; diag_wdata = 36'o0;
    mid();
    $display("txn DIAG clear 005");
    chk("hw_clr_gnt", diag_gnt, 1'b1);
    tick();
    diag_we = 2'b01; diag_wdata = 36'o777777000000;
    mid();
    $display("txn DIAG write left half 005");
    chk("hw_l_fm_we", fm_we, 2'b01);
    tick();
    diag_we = 2'b10; diag_wdata = 36'o0;
    mid();
    $display("txn DIAG write right half 005");
    chk("hw_r_fm_we", fm_we, 2'b10);
    tick();
    diag_we = 2'b00;
    mid();
    $display("txn DIAG read 005");
    chk("hw_rd_gnt", diag_gnt, 1'b1);
    tick();
    diag_req = 1'b0;
    mid();
    chk("hw_diag_rvalid", diag_rvalid, 1'b1);
    chk("hw_diag_rdata", diag_rdata, 36'o777777000000);
    chk("hw_parity", rparity, 1'b0);
    chk("hw_ebox_rvalid", ebox_rvalid, 1'b0);

    // ---------------- starvation bound, both requests held
    tick();
    ebox_req = 1'b1; ebox_we = 2'b00; ebox_addr = 7'o01;
    diag_req = 1'b1; diag_we = 2'b00; diag_addr = 7'o02;
    for (int i = 0; i < 10; i++) begin
      mid();
      $display("txn contended cycle %0d: ebox_gnt=%0b diag_gnt=%0b cnt=%0d",
               i, ebox_gnt, diag_gnt, starve_cnt);
      chk($sformatf("starve_dgnt_%0d", i), diag_gnt, exp_dg[i]);
      chk($sformatf("starve_egnt_%0d", i), ebox_gnt, !exp_dg[i]);
      chk($sformatf("starve_cnt_%0d", i), starve_cnt, 4'(exp_cnt[i]));
      tick();
    end

    // ---------------- diag_lock
    diag_lock = 1'b1; ebox_addr = 7'o03; diag_addr = 7'o40;
    mid();
    $display("txn locked: DIAG read 040");
    chk("lk_ebox_gnt0", ebox_gnt, 1'b0);
    chk("lk_diag_gnt", diag_gnt, 1'b1);
    chk("lk_fm_addr", fm_addr, 7'o40);
    tick();
    diag_req = 1'b0;
    mid();
    chk("lk_ebox_gnt1", ebox_gnt, 1'b0);
    chk("lk_diag_rvalid", diag_rvalid, 1'b1);
    chk("lk_idle_addr", fm_addr, 7'o40);
    tick();
    diag_lock = 1'b0;
    mid();
    $display("txn unlock: EBOX read 003");
    chk("ul_ebox_gnt", ebox_gnt, 1'b1);
    chk("ul_fm_addr", fm_addr, 7'o03);
    tick();
    diag_lock = 1'b1; ebox_req = 1'b1;
    mid();
    $display("txn lock with EBOX read in flight");
    chk("lk_inflight_rvalid", ebox_rvalid, 1'b1);
    chk("lk_inflight_gnt", ebox_gnt, 1'b0);

    // ---------------- back-to-back mixed reads
    tick();
    diag_lock = 1'b0;
    ebox_we = 2'b11; ebox_addr = 7'o21; ebox_wdata = 36'o111111222222;
    mid();
    $display("txn EBOX write 021");
    chk("bb_wa_gnt", ebox_gnt, 1'b1);
    tick();
    ebox_addr = 7'o22; ebox_wdata = 36'o333333444445;
    mid();
    $display("txn EBOX write 022");
    chk("bb_wb_gnt", ebox_gnt, 1'b1);
    tick();
    ebox_we = 2'b00; ebox_addr = 7'o21;
    mid();
    $display("txn EBOX read 021");
    chk("bb_ra_gnt", ebox_gnt, 1'b1);
    tick();
    ebox_req = 1'b0;
    diag_req = 1'b1; diag_we = 2'b00; diag_addr = 7'o22;
    mid();
    $display("txn DIAG read 022");
    chk("bb_rb_gnt", diag_gnt, 1'b1);
    chk("bb_a_ervalid", ebox_rvalid, 1'b1);
    chk("bb_a_erdata", ebox_rdata, 36'o111111222222);
    chk("bb_a_drdata", diag_rdata, 36'o0);
    chk("bb_a_parity", rparity, 1'b0);
    tick();
    diag_req = 1'b0;
    mid();
    chk("bb_b_dvalid", diag_rvalid, 1'b1);
    chk("bb_b_drdata", diag_rdata, 36'o333333444445);
    chk("bb_b_ervalid", ebox_rvalid, 1'b0);
    chk("bb_b_erdata", ebox_rdata, 36'o0);
    chk("bb_b_parity", rparity, 1'b1);

    // ---------------- mid-run reset beats a pending grant
    tick();
    ebox_req = 1'b1; ebox_addr = 7'o21; diag_req = 1'b1;
    mid();
    $display("txn contended before reset");
    chk("mr_pre_gnt", ebox_gnt, 1'b1);
    tick();
    crobar_n = 1'b0;
    mid();
    $display("txn reset with requests pending");
    chk("mr_gnt", {ebox_gnt, diag_gnt}, 2'b00);
    chk("mr_fm_addr_last", fm_addr, 7'o21);
    chk("mr_starve_pre", starve_cnt, 4'd1);
    chk("mr_rvalid_pre", ebox_rvalid, 1'b1);
    tick();
    mid();
    chk("mr_fm_addr_clr", fm_addr, 7'o00);
    chk("mr_starve_clr", starve_cnt, 4'd0);
    chk("mr_rvalid_clr", ebox_rvalid, 1'b0);
    tick();
    crobar_n = 1'b1;
    mid();
    $display("txn after mid-run reset");
    chk("mr_post_gnt", ebox_gnt, 1'b1);
    tick();
    ebox_req = 1'b0; diag_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
